hb_lsu_master: RTL and testbench



---
 rtl/hb_lsu_master_pkg.sv | 42 ++++
 rtl/hb_lsu_master_if.sv | 27 ++
 rtl/hb_lsu_master_tmo.sv | 36 +++
 rtl/hb_lsu_master.sv | 166 ++++++++++++++++
 tb/tb_hb_lsu_master.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hb_lsu_master_pkg.sv
// Shared XT high-speed bus definitions for core-side initiators.
// Width codes, LSU state encoding and load-extension helper.
package hb_lsu_master_pkg;

   localparam logic [1:0] W_BYTE  = 2'b00;
   localparam logic [1:0] W_HALF  = 2'b01;
   localparam logic [1:0] W_WORD  = 2'b10;
   localparam logic [1:0] W_DWORD = 2'b11;

   typedef logic [2:0] lsu_state_t;

   localparam lsu_state_t S_IDLE    = 3'd0;
   localparam lsu_state_t S_RD_REQ  = 3'd1;
   localparam lsu_state_t S_RD_WAIT = 3'd2;
   localparam lsu_state_t S_WR_REQ  = 3'd3;
   localparam lsu_state_t S_WR_WAIT = 3'd4;

   function automatic logic req_bad(
      input logic [1:0] width,
      input logic [1:0] addr_lo
   );
      return (width == W_DWORD)
          || (width == W_HALF && addr_lo[0])
          || (width == W_WORD && addr_lo != 2'b00);
   endfunction

   function automatic logic [31:0] load_extend(
      input logic [1:0]  width,
      input logic        uns,
      input logic [31:0] data
   );
      logic [31:0] r;
      r = data;
      case (width)
         W_BYTE:  r = {{24{~uns & data[7]}}, data[7:0]};
         W_HALF:  r = {{16{~uns & data[15]}}, data[15:0]};
         default: r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hb_lsu_master_if.sv
// XT high-speed bus request/response signals between
// an initiator (master) and a data-RAM/peripheral slave.
interface hb_lsu_master_if;

   logic [31:0] hb_raddr;
   logic [31:0] hb_waddr;
   logic [31:0] hb_wdata;
   logic [1:0]  hb_write_width;
   logic        hb_ren;
   logic        hb_wen;
   logic [31:0] hb_rdata;
   logic        hb_read_finish;
   logic        hb_write_finish;

   modport master (
      output hb_raddr, hb_waddr, hb_wdata, hb_write_width,
      output hb_ren, hb_wen,
      input  hb_rdata, hb_read_finish, hb_write_finish
   );

   modport slave (
      input  hb_raddr, hb_waddr, hb_wdata, hb_write_width,
      input  hb_ren, hb_wen,
      output hb_rdata, hb_read_finish, hb_write_finish
   );

endinterface

// File: rtl/hb_lsu_master_tmo.sv
// Finish-handshake watchdog; reusable by other bus initiators.
// hit fires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
module hb_lsu_master_tmo #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign hit = inc && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hb_lsu_master.sv
// Core-side load/store initiator for the XT high-speed bus.
// One outstanding transaction; all outputs registered.
module hb_lsu_master
   import hb_lsu_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic             hb_clk,
   input  logic             hb_rst_n,
   input  logic             req_valid,
   input  logic             req_write,
   input  logic [31:0]      req_addr,
   input  logic [1:0]       req_width,
   input  logic             req_unsigned,
   input  logic [31:0]      req_wdata,
   output logic             req_ready,
   output logic             rsp_done,
   output logic             rsp_error,
   output logic [31:0]      rsp_rdata,
   hb_lsu_master_if.master  bus
);

   lsu_state_t  state_q, state_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ren_q, ren_d;
   logic        wen_q, wen_d;
   logic [31:0] raddr_q, raddr_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  width_q, width_d;
   logic        uns_q, uns_d;
   logic        tmo_clr, tmo_inc, tmo_hit;

   assign tmo_inc = (state_q == S_RD_WAIT && !bus.hb_read_finish)
                 || (state_q == S_WR_WAIT && !bus.hb_write_finish);
   assign tmo_clr = !(state_q == S_RD_WAIT || state_q == S_WR_WAIT);

   hb_lsu_master_tmo #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_tmo (
      .clk   (hb_clk),
      .rst_n (hb_rst_n),
      .clr   (tmo_clr),
      .inc   (tmo_inc),
      .hit   (tmo_hit)
   );

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      ren_d   = 1'b0;
      wen_d   = wen_q;
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      width_d = width_q;
      uns_d   = uns_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_bad(req_width, req_addr[1:0])) begin
                  // rejected without touching the bus
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  ready_d = 1'b0;
                  width_d = req_width;
                  uns_d   = req_unsigned;
                  if (req_write) begin
                     waddr_d = req_addr;
                     wdata_d = req_wdata;
                     wen_d   = 1'b1;
                     state_d = S_WR_REQ;
                  end else begin
                     raddr_d = req_addr;
                     ren_d   = 1'b1;
                     state_d = S_RD_REQ;
                  end
               end
            end
         end
         S_RD_REQ: begin
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (bus.hb_read_finish) begin
               done_d  = 1'b1;
               rdata_d = load_extend(width_q, uns_q, bus.hb_rdata);
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else if (tmo_hit) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               ready_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WR_REQ, S_WR_WAIT: begin
            if (bus.hb_write_finish || tmo_hit) begin
               done_d  = 1'b1;
               err_d   = !bus.hb_write_finish;
               wen_d   = 1'b0;
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_WR_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            wen_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge hb_clk or negedge hb_rst_n) begin
      if (!hb_rst_n) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         raddr_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         width_q <= '0;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         width_q <= width_d;
         uns_q   <= uns_d;
      end
   end

   assign req_ready          = ready_q;
   assign rsp_done           = done_q;
   assign rsp_error          = err_q;
   assign rsp_rdata          = rdata_q;
   assign bus.hb_ren         = ren_q;
   assign bus.hb_wen         = wen_q;
   assign bus.hb_raddr       = raddr_q;
   assign bus.hb_waddr       = waddr_q;
   assign bus.hb_wdata       = wdata_q;
   assign bus.hb_write_width = width_q;

endmodule

// File: tb/tb_hb_lsu_master.sv
// Scoreboard bench for hb_lsu_master with a reactive bus slave.
// Expected responses come from a width/alignment/latency reference model.
module tb_hb_lsu_master;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_width = '0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        req_ready;
   logic        rsp_done;
   logic        rsp_error;
   logic [31:0] rsp_rdata;

   always #5 clk = ~clk;

   hb_lsu_master_if bus ();

   hb_lsu_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .hb_clk       (clk),
      .hb_rst_n     (rst_n),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_width    (req_width),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .rsp_done     (rsp_done),
      .rsp_error    (rsp_error),
      .rsp_rdata    (rsp_rdata),
      .bus          (bus)
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   int          cfg_k = 1;
   logic [31:0] cfg_rdval = '0;
   logic        cfg_wtie = 1'b0;
   int          rcd = 0;
   int          wcd = 0;
   logic        wact = 1'b0;
   int          ren_cnt = 0;
   int          wen_cnt = 0;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_wdata = '0;
   logic [1:0]  exp_width = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [1:0] wd);
      if (wd == 2'd0) return 32'h0000_00FF;
      if (wd == 2'd1) return 32'h0000_FFFF;
      return 32'hFFFF_FFFF;
   endfunction

   function automatic bit legal(input logic [31:0] a, input logic [1:0] wd);
      if (wd == 2'd3) return 1'b0;
      if (wd == 2'd1) return (a % 2) == 0;
      if (wd == 2'd2) return (a % 4) == 0;
      return 1'b1;
   endfunction

   // k: slave answers k cycles after the select; read k==0 never answers
   function automatic bit timed_out(input bit w, input int k);
      return (!w && k == 0) || k > TMO;
   endfunction

   function automatic exp_t model(input bit w, input logic [31:0] a,
                                  input logic [1:0] wd, input bit u,
                                  input logic [31:0] rv, input int k);
      exp_t        e;
      logic [31:0] v;
      e.acc = 0;
      if (!legal(a, wd)) begin
         e.err = 1'b1; e.rdata = '0; e.lat = 1;
      end else if (timed_out(w, k)) begin
         e.err = 1'b1; e.rdata = '0; e.lat = TMO + 2;
      end else begin
         e.err = 1'b0; e.lat = k + 2;
         v = rv & lane_mask(wd);
         if (w) e.rdata = '0;
         else if (wd == 2'd0 && !u && v >= 32'h80) e.rdata = v - 32'h100;
         else if (wd == 2'd1 && !u && v >= 32'h8000) e.rdata = v - 32'h1_0000;
         else e.rdata = v;
      end
      return e;
   endfunction

   // reactive slave plus bus-side checks
   initial begin
      logic wfin;
      bus.hb_rdata = '0;
      bus.hb_read_finish = 1'b0;
      bus.hb_write_finish = 1'b0;
      forever begin
         @(negedge clk);
         bus.hb_read_finish = 1'b0;
         bus.hb_rdata = $urandom;
         if (rcd > 0) begin
            rcd--;
            if (rcd == 0) begin
               bus.hb_read_finish = 1'b1;
               bus.hb_rdata = cfg_rdval;
            end
         end
         if (bus.hb_ren) begin
            ren_cnt++;
            if (cfg_k > 0) rcd = cfg_k;
            chk("raddr", 64'(bus.hb_raddr), 64'(exp_addr));
            chk("rd_width", 64'(bus.hb_write_width), 64'(exp_width));
         end
         wfin = 1'b0;
         if (wcd > 0) begin
            wcd--;
            if (wcd == 0) wfin = 1'b1;
         end
         if (bus.hb_wen) begin
            wen_cnt++;
            chk("waddr", 64'(bus.hb_waddr), 64'(exp_addr));
            chk("wdata", 64'(bus.hb_wdata), 64'(exp_wdata));
            chk("wr_width", 64'(bus.hb_write_width), 64'(exp_width));
            if (!wact && !cfg_wtie) wcd = cfg_k;
            wact = 1'b1;
         end else begin
            wact = 1'b0;
         end
         bus.hb_write_finish = cfg_wtie | wfin;
      end
   end

   // response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'(rsp_done), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_error", 64'(rsp_error), 64'(e.err));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
               chk("ready_at_done", 64'(req_ready), 64'd1);
            end
         end
      end
   end

   task automatic issue(input bit w, input logic [31:0] a,
                        input logic [1:0] wd, input bit u,
                        input logic [31:0] wdat, input logic [31:0] rv,
                        input int k, input bit rst_mid);
      exp_t e;
      int   guard;
      int   exp_ren;
      int   exp_wen;
      guard = 0;
      do begin
         @(negedge clk); #1;
         guard++;
      end while ((!req_ready || rcd != 0 || wcd != 0) && guard < 200);
      chk("idle_wait", 64'(guard < 200), 64'd1);
      cfg_k = k;
      cfg_rdval = rv & lane_mask(wd);
      if (w) cfg_wtie = (k == 0);
      ren_cnt = 0;
      wen_cnt = 0;
      exp_addr = a;
      exp_wdata = wdat;
      exp_width = wd;
      req_valid = 1'b1;
      req_write = w;
      req_addr = a;
      req_width = wd;
      req_unsigned = u;
      req_wdata = wdat;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr = $urandom;
      req_width = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata = $urandom;
      e = model(w, a, wd, u, rv, k);
      e.acc = cyc;
      if (rst_mid) begin
         @(posedge clk); #2;
         rst_n = 1'b0;
         #1;
         chk("rst_ctrl",
             64'({req_ready, rsp_done, rsp_error, bus.hb_ren,
                  bus.hb_wen, bus.hb_write_width}),
             64'(7'b100_0000));
         chk("rst_data",
             64'(rsp_rdata | bus.hb_raddr | bus.hb_waddr | bus.hb_wdata),
             64'd0);
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      sb.push_back(e);
      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      chk("done_seen", 64'(sb.size()), 64'd0);
      sb.delete();
      exp_ren = 0;
      exp_wen = 0;
      if (legal(a, wd)) begin
         if (!w) exp_ren = 1;
         else if (timed_out(w, k)) exp_wen = TMO + 1;
         else exp_wen = k + 1;
      end
      chk("ren_cycles", 64'(ren_cnt), 64'(exp_ren));
      chk("wen_cycles", 64'(wen_cnt), 64'(exp_wen));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          w;
      logic [1:0]  wd;
      logic [31:0] a;
      int          k;
      int          r;
      repeat (3) @(negedge clk);
      chk("reset_ctrl",
          64'({req_ready, rsp_done, rsp_error, bus.hb_ren,
               bus.hb_wen, bus.hb_write_width}),
          64'(7'b100_0000));
      chk("reset_data",
          64'(rsp_rdata | bus.hb_raddr | bus.hb_waddr | bus.hb_wdata),
          64'd0);
      rst_n = 1'b1;

      issue(0, 32'h103, 2'd0, 0, 32'h0, 32'hF0, 1, 0);
      issue(0, 32'h103, 2'd0, 1, 32'h0, 32'hF0, 1, 0);
      issue(0, 32'h102, 2'd1, 0, 32'h0, 32'h8001, 1, 0);
      issue(0, 32'h100, 2'd2, 0, 32'h0, 32'hDEADBEEF, 1, 0);
      issue(1, 32'h200, 2'd2, 0, 32'h12345678, 32'h0, 0, 0);
      issue(1, 32'h201, 2'd1, 0, 32'hABCD, 32'h0, 0, 0);
      issue(0, 32'h102, 2'd2, 0, 32'h0, 32'h1, 1, 0);
      issue(0, 32'h104, 2'd3, 0, 32'h0, 32'h1, 1, 0);
      issue(0, 32'h104, 2'd2, 0, 32'h0, 32'h0, 0, 0);
      issue(0, 32'h108, 2'd2, 0, 32'h0, 32'h5A5A_0001, TMO, 0);
      issue(1, 32'h20C, 2'd2, 0, 32'h0BAD_CAFE, 32'h0, TMO, 0);
      issue(1, 32'h210, 2'd0, 0, 32'h77, 32'h0, TMO + 4, 0);
      issue(0, 32'h104, 2'd2, 0, 32'h0, 32'h0, 0, 1);
      issue(0, 32'h300, 2'd2, 0, 32'h0, 32'hCAFE_F00D, 1, 0);

      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom);
         wd = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~32'(lane_mask(wd) >> 8);
         if (wd == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         r = $urandom_range(0, 9);
         if (r == 0) k = w ? TMO + 3 : 0;
         else k = $urandom_range(w ? 0 : 1, 4);
         issue(w, a, wd, 1'($urandom), $urandom, $urandom, k, 0);
      end

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
